// File: rtl/pea_pkg.sv
// ---------------------------------------------------------------------------
// pea_pkg
// Shared types and default sizing for the PE functional-unit array.
//   div_fsm_t      : divider control states (IDLE, EXEC, DONE)
//   N_BITS_DIV     : default divider operand width
//   RADIX_LOG2_DIV : default quotient bits retired per cycle
// ---------------------------------------------------------------------------
package pea_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } div_fsm_t;

  localparam int N_BITS_DIV     = 32;
  localparam int RADIX_LOG2_DIV = 1;

endpackage

// File: rtl/r_div_step.sv
// ---------------------------------------------------------------------------
// r_div_step
// One combinational restoring-division radix step.
// Ports:
//   rem_i  [N_BITS-1:0]     : current partial remainder (always < |d|)
//   bits_i [RADIX_LOG2-1:0] : next dividend bits, MSB first
//   d_i    [N_BITS-1:0]     : divisor magnitude
//   rem_o  [N_BITS-1:0]     : new partial remainder
//   k_o    [RADIX_LOG2-1:0] : quotient digit retired this step
// ---------------------------------------------------------------------------
module r_div_step
  import pea_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DIV,
  parameter int RADIX_LOG2 = RADIX_LOG2_DIV
) (
  input  logic [N_BITS-1:0]     rem_i,
  input  logic [RADIX_LOG2-1:0] bits_i,
  input  logic [N_BITS-1:0]     d_i,
  output logic [N_BITS-1:0]     rem_o,
  output logic [RADIX_LOG2-1:0] k_o
);

  localparam int W = N_BITS + RADIX_LOG2;

  logic [W-1:0]      rem_sh;
  logic [W-1:0]      d_ext;
  logic [W-1:0]      prod;
  logic [N_BITS-1:0] prod_sel;

  // Widened by RADIX_LOG2 so an unsigned 2^(N_BITS-1) magnitude never overflows.
  assign rem_sh = {rem_i, bits_i};
  assign d_ext  = {{RADIX_LOG2{1'b0}}, d_i};

  // Candidates are tried in ascending order, so the last one that fits is
  // the largest digit. The true remainder is < |d|, so its low N_BITS
  // are exact even though the subtraction is done at N_BITS width.
  always_comb begin
    k_o      = '0;
    prod     = '0;
    prod_sel = '0;
    for (int k = 1; k < (1 << RADIX_LOG2); k++) begin
      prod = W'(k) * d_ext;
      if (rem_sh >= prod) begin
        k_o      = RADIX_LOG2'(k);
        prod_sel = prod[N_BITS-1:0];
      end
    end
    rem_o = rem_sh[N_BITS-1:0] - prod_sel;
  end

endmodule

// File: rtl/r_div_hs.sv
// ---------------------------------------------------------------------------
// r_div_hs
// Multicycle restoring divider with valid/ready handshakes, signed/unsigned
// mode, defined divide-by-zero result and flush.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i
//   valid_i/ready_o, n_i, d_i, signed_i      : operand side
//   valid_o/ready_i, q_o, r_o, dbz_o         : result side
// Build option:
//   R_DIV_DBZ_FAST_EN : divide-by-zero skips the radix iterations
//                       (result available 2 cycles after accept).
// ---------------------------------------------------------------------------
module r_div_hs
  import pea_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DIV,
  parameter int RADIX_LOG2 = RADIX_LOG2_DIV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [N_BITS-1:0] n_i,
  input  logic [N_BITS-1:0] d_i,
  input  logic              signed_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_BITS-1:0] q_o,
  output logic [N_BITS-1:0] r_o,
  output logic              dbz_o
);

  localparam int N_STEPS = N_BITS / RADIX_LOG2;
  localparam int CW      = $clog2(N_STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(N_STEPS);

  function automatic logic [N_BITS-1:0] neg_if(input logic [N_BITS-1:0] v,
                                               input logic              en);
    return en ? (~v + 1'b1) : v;
  endfunction

  div_fsm_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic [N_BITS-1:0]     quo;     // dividend bits shift out the top, digits shift in below
  logic [N_BITS-1:0]     rem;
  logic [N_BITS-1:0]     d_abs;
  logic [N_BITS-1:0]     n_raw;
  logic                  neg_q;
  logic                  neg_r;
  logic                  d_zero;
  logic [N_BITS-1:0]     rem_nxt;
  logic [RADIX_LOG2-1:0] k;
  logic                  accept;
  logic                  last;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign accept  = (state == IDLE) && valid_i && !flush_i;
  // cnt reaches LAST once every radix step has been applied; that extra
  // EXEC cycle registers the sign-corrected result.
  assign last    = (state == EXEC) && (cnt == LAST);

  r_div_step #(
    .N_BITS     (N_BITS),
    .RADIX_LOG2 (RADIX_LOG2)
  ) u_step (
    .rem_i  (rem),
    .bits_i (quo[N_BITS-1 -: RADIX_LOG2]),
    .d_i    (d_abs),
    .rem_o  (rem_nxt),
    .k_o    (k)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = EXEC;
      EXEC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (accept) begin
`ifdef R_DIV_DBZ_FAST_EN
      // Divide-by-zero jumps to the final iteration; the special-case mux
      // ignores whatever that step computes.
      cnt <= (d_i == '0) ? LAST - 1'b1 : '0;
`else
      cnt <= '0;
`endif
    end else if ((state == EXEC) && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Operand capture and radix iteration
  always_ff @(posedge clk_i) begin
    if (accept) begin
      quo    <= neg_if(n_i, signed_i & n_i[N_BITS-1]);
      d_abs  <= neg_if(d_i, signed_i & d_i[N_BITS-1]);
      rem    <= '0;
      n_raw  <= n_i;
      neg_q  <= signed_i & (n_i[N_BITS-1] ^ d_i[N_BITS-1]);
      neg_r  <= signed_i & n_i[N_BITS-1];
      d_zero <= (d_i == '0);
    end else if ((state == EXEC) && !last) begin
      rem <= rem_nxt;
      quo <= {quo[N_BITS-RADIX_LOG2-1:0], k};
    end
  end

  // Sign correction and special results
  // MIN / -1 needs no special case: |MIN| / 1 = 2^(N_BITS-1), which is the
  // MIN bit pattern, and neg_q is 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o   <= '0;
      r_o   <= '0;
      dbz_o <= 1'b0;
    end else if (last && !flush_i) begin
      q_o   <= d_zero ? '1    : neg_if(quo, neg_q);
      r_o   <= d_zero ? n_raw : neg_if(rem, neg_r);
      dbz_o <= d_zero;
    end
  end

endmodule

// File: tb/tb_r_div_hs.sv
module tb_r_div_hs;

`ifdef R_DIV_DBZ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i, signed_i;
  logic [31:0] n_i, d_i;
  logic        rdy2, vld2, z2, rdy4, vld4, z4;
  logic [31:0] q2, r2, q4, r4;

  always #5 clk = ~clk;

  r_div_hs #(.N_BITS(32), .RADIX_LOG2(1)) u_r2 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(rdy2), .n_i(n_i), .d_i(d_i), .signed_i(signed_i),
    .valid_o(vld2), .ready_i(ready_i), .q_o(q2), .r_o(r2), .dbz_o(z2));

  r_div_hs #(.N_BITS(32), .RADIX_LOG2(2)) u_r4 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(rdy4), .n_i(n_i), .d_i(d_i), .signed_i(signed_i),
    .valid_o(vld4), .ready_i(ready_i), .q_o(q4), .r_o(r4), .dbz_o(z4));

  int total = 0;
  int bad   = 0;

  logic [31:0] eq, er;
  logic        ez;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
  // and give the remainder the dividend's sign.
  task automatic model(input logic [31:0] n, input logic [31:0] d, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint nn, dd;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF; r = n; z = 1'b1;
    end else begin
      if (s) begin
        nn = longint'($signed(n)); dd = longint'($signed(d));
      end else begin
        nn = longint'({32'd0, n}); dd = longint'({32'd0, d});
      end
      q = 32'(nn / dd); r = 32'(nn % dd); z = 1'b0;
    end
  endtask

  // Called at a negedge with both dividers idle.
  task automatic run_op(input string tag, input logic [31:0] n, input logic [31:0] d,
                        input logic s);
    bit got2, got4;
    int lat2, lat4, exp2, exp4;
    logic [31:0] cq2, cr2, cq4, cr4;
    logic cz2, cz4;
    model(n, d, s, eq, er, ez);
    exp2 = (FAST && d == 0) ? 2 : 33;
    exp4 = (FAST && d == 0) ? 2 : 17;
    chk({tag, "_rdy"}, 64'({rdy2, rdy4}), 64'(2'b11));
    n_i = n; d_i = d; signed_i = s; valid_i = 1'b1;
    @(posedge clk);
    got2 = 0; got4 = 0; lat2 = 0; lat4 = 0;
    cq2 = '0; cr2 = '0; cz2 = 0; cq4 = '0; cr4 = '0; cz4 = 0;
    for (int e = 1; e <= 60 && !(got2 && got4); e++) begin
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0; n_i = $urandom; d_i = $urandom; signed_i = 1'($urandom);
      if (vld2 && !got2) begin got2 = 1; lat2 = e; cq2 = q2; cr2 = r2; cz2 = z2; end
      if (vld4 && !got4) begin got4 = 1; lat4 = e; cq4 = q4; cr4 = r4; cz4 = z4; end
    end
    chk({tag, "_lat2"}, 64'(lat2), 64'(exp2));
    chk({tag, "_lat4"}, 64'(lat4), 64'(exp4));
    chk({tag, "_q2"}, 64'(cq2), 64'(eq));
    chk({tag, "_r2"}, 64'(cr2), 64'(er));
    chk({tag, "_z2"}, 64'(cz2), 64'(ez));
    chk({tag, "_q4"}, 64'(cq4), 64'(eq));
    chk({tag, "_r4"}, 64'(cr4), 64'(er));
    chk({tag, "_z4"}, 64'(cz4), 64'(ez));
    if (ready_i) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic abort_test(input string tag, input bit use_rst);
    bit seen;
    n_i = 32'd100; d_i = 32'd7; signed_i = 1'b0; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_rst) rst_i = 1'b1;
    else         flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0; flush_i = 1'b0;
    chk({tag, "_idle"}, 64'({rdy2, rdy4, vld2, vld4}), 64'(4'b1100));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | vld2 | vld4;
    end
    chk({tag, "_novld"}, 64'(seen), 64'(0));
    run_op({tag, "_9d3"}, 32'd9, 32'd3, 1'b0);
  endtask

  logic [31:0] dn [10] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000,
                           32'd123, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd123};
  logic [31:0] dd [10] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF,
                           32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd0};
  logic        ds [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [31:0] rn, rd;
    logic rs;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    signed_i = 1'b0; n_i = '0; d_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_r2", 64'({rdy2, vld2, z2, q2, r2}), 64'({1'b1, 1'b0, 1'b0, 32'd0, 32'd0}));
    chk("rst_r4", 64'({rdy4, vld4, z4, q4, r4}), 64'({1'b1, 1'b0, 1'b0, 32'd0, 32'd0}));

    for (int i = 0; i < 10; i++) run_op($sformatf("dir%0d", i), dn[i], dd[i], ds[i]);

    for (int i = 0; i < 30; i++) begin
      rn = $urandom; rd = $urandom; rs = 1'($urandom);
      case ($urandom_range(0, 7))
        0: rd = 32'd0;
        1: rd = 32'hFFFF_FFFF;
        2: rn = 32'h8000_0000;
        3: rd = 32'($urandom_range(1, 300));
        4: begin rn = 32'($urandom_range(0, 5000)); rd = 32'($urandom_range(1, 70)); end
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rn, rd, rs);
    end

    // Result backpressure
    ready_i = 1'b0;
    run_op("bp", 32'd1000, 32'd7, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c), 64'({vld2, rdy2, q2, r2}), 64'({1'b1, 1'b0, eq, er}));
    end
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", 64'({rdy2, vld2, rdy4, vld4}), 64'(4'b1010));
    run_op("bp_next", 32'd55, 32'd5, 1'b0);

    abort_test("flush", 1'b0);
    abort_test("reset", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
